// File: rtl/reset_sequencer.sv
// reset_sequencer: debounced button/soft/PLL-loss reset triggers, PLL hold gate, staged domain reset release
module reset_sequencer #(
  parameter int NUM_BUTTONS = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic [NUM_BUTTONS-1:0] EDGE_POLARITY = {NUM_BUTTONS{1'b0}},
  parameter int HOLD_CYCLES = 255,
  parameter int NUM_DOMAINS = 2,
  parameter int STAGE_CYCLES = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_locked,
  input  logic [NUM_BUTTONS-1:0] btn_in,
  input  logic soft_req,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic sys_busy,
  output logic [NUM_BUTTONS+1:0] cause,
  output logic [CNT_WIDTH-1:0] reset_count
);
  localparam int NB = NUM_BUTTONS;
  localparam int ND = NUM_DOMAINS;
  localparam int CS = NUM_BUTTONS + 2;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int SW = $clog2(STAGE_CYCLES) + 1;
  localparam int IW = $clog2(NUM_DOMAINS) + 1;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t state, state_n;
  logic [NB-1:0] s1, s2, lvl, lvl_d, btn_trig, btn_low;
  logic [DW-1:0] dcnt [NB];
  logic [HW-1:0] hold, hold_n;
  logic [SW-1:0] stage, stage_n;
  logic [IW-1:0] idx, idx_n;
  logic [ND-1:0] dr_n;
  logic [CS-1:0] cause_n;
  logic [CNT_WIDTH-1:0] count_n;
  logic pll_d, pll_loss, trig;
  // two-flop synchronisers and per-channel stability counters feeding the debounced levels
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      lvl_d <= '0;
      for (int i = 0; i < NB; i++) dcnt[i] <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      lvl_d <= lvl;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == lvl[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i] <= s2[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end
  assign btn_trig = (EDGE_POLARITY & lvl & ~lvl_d) | (~EDGE_POLARITY & ~lvl & lvl_d);
  assign btn_low = btn_trig & (~btn_trig + 1'b1);
  assign pll_loss = pll_d & ~pll_locked & (state != HOLD);
  assign trig = pll_loss | soft_req | (|btn_trig);
  // next state: any trigger forces a full restart of the hold, otherwise hold/stage progression
  always_comb begin
    state_n = state;
    hold_n = hold;
    stage_n = stage;
    idx_n = idx;
    dr_n = domain_reset;
    cause_n = cause;
    count_n = reset_count;
    if (trig) begin
      state_n = HOLD;
      hold_n = '0;
      stage_n = '0;
      idx_n = '0;
      dr_n = '1;
      cause_n = pll_loss ? CS'(1) : soft_req ? CS'(2) : {btn_low, 2'b00};
      count_n = &reset_count ? reset_count : reset_count + 1'b1;
    end else if (state == HOLD) begin
      dr_n = '1;
      hold_n = !pll_locked ? '0 : hold + 1'b1;
      if (pll_locked && hold == HW'(HOLD_CYCLES - 1)) begin
        dr_n[0] = 1'b0;
        hold_n = '0;
        idx_n = IW'(1);
        stage_n = '0;
        state_n = (ND == 1) ? RUN : RELEASE;
      end
    end else if (state == RELEASE) begin
      stage_n = stage + 1'b1;
      if (stage == SW'(STAGE_CYCLES - 1)) begin
        dr_n = domain_reset & ~(ND'(1) << idx);
        stage_n = '0;
        idx_n = idx + 1'b1;
        state_n = (idx == IW'(ND - 1)) ? RUN : RELEASE;
      end
    end else dr_n = '0;
  end
  // sequencer registers; sys_busy follows the next-state resets so it lines up with domain_reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HOLD;
      hold <= '0;
      stage <= '0;
      idx <= '0;
      pll_d <= 1'b0;
      domain_reset <= '1;
      sys_busy <= 1'b1;
      cause <= CS'(1);
      reset_count <= '0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      stage <= stage_n;
      idx <= idx_n;
      pll_d <= pll_locked;
      domain_reset <= dr_n;
      sys_busy <= |dr_n;
      cause <= cause_n;
      reset_count <= count_n;
    end
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised reset controller for the Murax-class top levels. Sits between the PLL lock, the board buttons, and the CPU and peripheral clock domains' reset inputs.
- Takes N asynchronous buttons and synchronises and debounces each one. Each button triggers on a selectable edge.
- Gates reset release on PLL lock plus a hold time, then releases several reset outputs in staged order.
- Records the cause of the last reset and counts reset sequences.

Parameters:
- NUM_BUTTONS, 2: number of raw button inputs.
- DEBOUNCE_CYCLES, 16: cycles a synchronised input must stay stable before it is accepted (>=2).
- EDGE_POLARITY, {NUM_BUTTONS{1'b0}}: per-button trigger edge; 0 = falling edge of debounced level, 1 = rising edge.
- HOLD_CYCLES, 255: locked cycles that all domains stay in reset before release starts (>=1).
- NUM_DOMAINS, 2: number of staged reset outputs (>=1).
- STAGE_CYCLES, 4: cycles between successive domain releases (>=1).
- CNT_WIDTH, 8: width of the reset_count output.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high global reset.
- pll_locked  in  1  PLL lock indicator, synchronous to clk.
- btn_in  in  NUM_BUTTONS  raw asynchronous buttons.
- soft_req  in  1  one-cycle software reset request.
- domain_reset  out  NUM_DOMAINS  active-high domain resets; bit 0 is released first.
- sys_busy  out  1  high while any domain_reset bit is high.
- cause  out  NUM_BUTTONS+2  one-hot, sticky cause of the last reset; bit0 = POR/PLL loss, bit1 = soft, bit2+i = button i.
- reset_count  out  CNT_WIDTH  saturating count of triggered sequences.

Behaviour:
- Reset values:
  - domain_reset all 1, sys_busy 1.
  - cause = 1 (bit0), reset_count 0.
  - FSM in HOLD, all counters 0.
  - Sync flops 0, debounced levels 0.
- Sync and debounce:
  - btn_in passes through 2 flops per channel.
  - A per-channel counter clears whenever the synced value equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the value still differing, the debounced level takes the synced value and the counter clears.
  - Latency from a clean btn_in change to the debounced change is 2+DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - A trigger is a one-cycle pulse on the configured edge of the debounced level.
- Trigger sources:
  - Any button trigger.
  - soft_req.
  - pll_locked falling while in RELEASE or RUN.
- FSM state HOLD:
  - All domain_reset bits are 1.
  - Hold counter increments while pll_locked=1 and clears while pll_locked=0.
  - Loss of lock in HOLD is not a trigger: no change to cause or reset_count.
  - At counter==HOLD_CYCLES-1 with pll_locked=1:
    - domain_reset[0] goes to 0 at the next edge, stage index becomes 1, stage counter 0.
    - Next state is RELEASE, or RUN if NUM_DOMAINS==1.
- FSM state RELEASE:
  - Stage counter increments each cycle.
  - At STAGE_CYCLES-1: domain_reset[idx] goes to 0, counter clears, idx increments.
  - Releasing domain NUM_DOMAINS-1 moves the FSM to RUN.
  - Domain k deasserts k*STAGE_CYCLES cycles after domain 0. Release order is strictly ascending.
- FSM state RUN:
  - All domain_reset bits are 0. The FSM waits for a trigger.
- Trigger in any state (HOLD, RELEASE or RUN), sampled at edge t:
  - At t+1: all domain_reset bits are 1, FSM is in HOLD, hold and stage counters are 0.
  - cause is overwritten with a single one-hot bit.
  - reset_count increments by exactly 1 per cycle containing any trigger, saturating at all-ones.
- Simultaneous triggers: priority PLL loss > soft_req > lowest-index button. Only the winner is recorded in cause.
- A trigger in HOLD restarts the hold time fully.
- sys_busy is a registered OR of the next-state domain_reset, so it is cycle-aligned with domain_reset.
- reset at any time:
  - Returns all state to reset values next edge, including cause=1 and reset_count=0.
  - Debounced levels reset to 0. A button held at 1 through reset produces a rising edge after debounce, which triggers if EDGE_POLARITY=1.

Test Plan:
- Defaults, pll_locked=1, reset deasserted at cycle 0 -> domain_reset[0] falls at cycle 255 and [1] at cycle 259. sys_busy falls with [1]. cause=4'b0001, reset_count=0.
- pll_locked drops for 3 cycles when the hold count is 100, then returns -> no cause or count change. domain_reset[0] falls 255 cycles after lock returns.
- Button0 (falling-edge trigger) pulsed high for 10 cycles -> no trigger. Held high 40 cycles, then low -> all domains reset 2+16+1 cycles after the fall. cause=4'b0100, reset_count=1.
- soft_req and a button1 trigger in the same cycle -> cause=4'b0010, reset_count increments by 1 only.
- soft_req in RELEASE after domain 0 is released -> domain_reset=2'b11 next cycle. A full 255-cycle hold precedes re-release.
- CNT_WIDTH=2, five soft_req pulses spaced 300 cycles apart -> reset_count reads 1,2,3,3,3.
